// File: rtl/snn_timestep_scheduler.sv
// Run sequencer for snn_core_top: clears the neurons, then per timestep fetches the input
// spike batches, fires each layer in order and enables the output spike counters.
module snn_timestep_scheduler #(
    parameter int NUM_LAYERS                     = 2,
    parameter int MAX_TIMESTEPS_BITS             = 8,
    parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 1
) (
    input  logic                                                   S_AXI_ACLK,
    input  logic                                                   S_AXI_ARESET,
    input  logic                                                   start,
    input  logic                                                   abort,
    input  logic [MAX_TIMESTEPS_BITS:0]                            sim_time,
    input  logic [NUM_LAYERS-1:0]                                  layer_done,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [MAX_TIMESTEPS_BITS-1:0]                          timestep,
    output logic                                                   pat_rd_en,
    output logic [MAX_TIMESTEPS_BITS+SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] pat_rd_addr,
    output logic                                                   pat_we,
    output logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0]              pat_sel,
    output logic                                                   neuron_clr,
    output logic [NUM_LAYERS-1:0]                                  layer_start,
    output logic                                                   spk_cnt_en
);

    localparam int MTB = MAX_TIMESTEPS_BITS;
    localparam int W   = SPIKE_PATTERN_BATCH_ADDR_WIDTH;
    localparam int NB  = 2 ** W;
    localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic [MTB:0]  ONE_T      = (MTB+1)'(1);
    localparam logic [W-1:0]  LAST_BATCH = W'(NB - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        LATCH,
        LAYER,
        NEXT,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [MTB:0]    sim_time_q;
    logic [MTB-1:0]  timestep_q;
    logic [W-1:0]    batch_q;
    logic [LW-1:0]   layer_idx_q;
    logic            layer_fresh_q;
    logic            zero_run_q;
    logic            pat_we_q;
    logic [W-1:0]    pat_sel_q;

    logic            last_batch;
    logic            last_layer;
    logic            layer_ack;
    logic            ts_last;

    assign last_batch = (batch_q == LAST_BATCH);
    assign last_layer = (layer_idx_q == LAST_LAYER);
    // The layer_start cycle itself never accepts layer_done, so a stale level cannot skip a layer.
    assign layer_ack  = layer_done[layer_idx_q] && !layer_fresh_q;
    assign ts_last    = ({1'b0, timestep_q} == (sim_time_q - ONE_T));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (sim_time == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: state_next = FETCH;
            FETCH: begin
                if (last_batch) begin
                    state_next = LATCH;
                end
            end
            LATCH: state_next = LAYER;
            LAYER: begin
                if (layer_ack && last_layer) begin
                    state_next = NEXT;
                end
            end
            NEXT:    state_next = ts_last ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        pat_rd_en   = 1'b0;
        pat_rd_addr = '0;
        neuron_clr  = 1'b0;
        layer_start = '0;
        spk_cnt_en  = 1'b0;
        unique case (state)
            CLEAR: begin
                busy       = 1'b1;
                neuron_clr = 1'b1;
            end
            FETCH: begin
                busy        = 1'b1;
                pat_rd_en   = 1'b1;
                pat_rd_addr = {timestep_q, batch_q};
            end
            LATCH: busy = 1'b1;
            LAYER: begin
                busy = 1'b1;
                if (layer_fresh_q) begin
                    layer_start = NUM_LAYERS'(1) << layer_idx_q;
                end
                spk_cnt_en = layer_ack && last_layer;
            end
            NEXT: busy = 1'b1;
            // An empty run has no working cycles, so its DONE cycle is the one busy cycle.
            DONE: begin
                done = 1'b1;
                busy = zero_run_q;
            end
            default: ;
        endcase
    end

    assign timestep = timestep_q;
    assign pat_we   = pat_we_q;
    assign pat_sel  = pat_sel_q;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sim_time_q    <= '0;
            timestep_q    <= '0;
            batch_q       <= '0;
            layer_idx_q   <= '0;
            layer_fresh_q <= 1'b0;
            zero_run_q    <= 1'b0;
            pat_we_q      <= 1'b0;
            pat_sel_q     <= '0;
        end else if (abort) begin
            timestep_q    <= '0;
            batch_q       <= '0;
            layer_idx_q   <= '0;
            layer_fresh_q <= 1'b0;
            zero_run_q    <= 1'b0;
            pat_we_q      <= 1'b0;
            pat_sel_q     <= '0;
        end else begin
            // Pattern data returns one cycle after the read, so the write strobe trails the read.
            pat_we_q  <= (state == FETCH);
            pat_sel_q <= (state == FETCH) ? batch_q : '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sim_time_q <= sim_time;
                        timestep_q <= '0;
                        batch_q    <= '0;
                        zero_run_q <= (sim_time == '0);
                    end
                end
                FETCH: begin
                    batch_q <= last_batch ? '0 : batch_q + W'(1);
                end
                LATCH: begin
                    layer_idx_q   <= '0;
                    layer_fresh_q <= 1'b1;
                end
                LAYER: begin
                    layer_fresh_q <= 1'b0;
                    if (layer_ack) begin
                        if (last_layer) begin
                            layer_idx_q <= '0;
                        end else begin
                            layer_idx_q   <= layer_idx_q + LW'(1);
                            layer_fresh_q <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (!ts_last) begin
                        timestep_q <= timestep_q + MTB'(1);
                    end
                end
                DONE: zero_run_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler: table of whole runs with hand-computed counts,
// plus hand-written abort, stray layer_done, back-to-back start and async reset sequences.
module tb_snn_timestep_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [8:0] sim_time;
    logic [1:0] layer_done;
    logic       busy;
    logic       done;
    logic [7:0] timestep;
    logic       pat_rd_en;
    logic [8:0] pat_rd_addr;
    logic       pat_we;
    logic [0:0] pat_sel;
    logic       neuron_clr;
    logic [1:0] layer_start;
    logic       spk_cnt_en;

    logic [1:0] auto_done;
    logic [1:0] man_done;
    bit         auto_resp;
    int         resp_delay;
    int         cnt [2];

    int applied;
    int miscompares;

    typedef struct {
        int sim_t;
        int delay;
        int exp_busy;
        int exp_spk;
        int exp_clr;
        int exp_rd;
    } vec_t;

    vec_t vecs [6];

    snn_timestep_scheduler #(
        .NUM_LAYERS(2),
        .MAX_TIMESTEPS_BITS(8),
        .SPIKE_PATTERN_BATCH_ADDR_WIDTH(1)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .start(start),
        .abort(abort),
        .sim_time(sim_time),
        .layer_done(layer_done),
        .busy(busy),
        .done(done),
        .timestep(timestep),
        .pat_rd_en(pat_rd_en),
        .pat_rd_addr(pat_rd_addr),
        .pat_we(pat_we),
        .pat_sel(pat_sel),
        .neuron_clr(neuron_clr),
        .layer_start(layer_start),
        .spk_cnt_en(spk_cnt_en)
    );

    always #5 clk = ~clk;

    assign layer_done = auto_resp ? auto_done : man_done;

    // Layer model: layer_done[i] pulses resp_delay cycles after layer_start[i] is seen.
    always @(posedge clk) begin
        #1;
        auto_done = '0;
        for (int i = 0; i < 2; i++) begin
            if (auto_resp) begin
                if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0) auto_done[i] = 1'b1;
                end
                if (layer_start[i]) cnt[i] = resp_delay;
            end else begin
                cnt[i] = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int         busy_n = 0, spk_n = 0, done_n = 0, clr_n = 0, rd_n = 0;
        int         addr_err = 0, we_err = 0, ts_err = 0;
        logic       prev_rd = 1'b0;
        logic [8:0] prev_addr = '0;
        logic [8:0] last_addr = '0;
        logic [7:0] prev_ts = '0;
        bit         finished = 0;
        resp_delay = v.delay;
        auto_resp  = 1;
        @(posedge clk);
        #1;
        sim_time = 9'(v.sim_t);
        start    = 1'b1;
        for (int c = 0; c < 5000 && !finished; c++) begin
            @(posedge clk);
            #1;
            start    = 1'b0;
            sim_time = 9'd3;
            #2;
            if (busy) busy_n++;
            if (spk_cnt_en) spk_n++;
            if (neuron_clr) clr_n++;
            if (pat_we !== prev_rd || (prev_rd && pat_sel !== prev_addr[0])) we_err++;
            if (pat_rd_en) begin
                if (pat_rd_addr !== 9'(rd_n)) addr_err++;
                last_addr = pat_rd_addr;
                rd_n++;
            end
            if (busy && timestep < prev_ts) ts_err++;
            prev_ts   = timestep;
            prev_rd   = pat_rd_en;
            prev_addr = pat_rd_addr;
            if (done) begin
                done_n++;
                finished = 1;
            end
        end
        checkOutput({tag, " busy_cycles"}, busy_n, v.exp_busy);
        checkOutput({tag, " spk_cnt_en"}, spk_n, v.exp_spk);
        checkOutput({tag, " neuron_clr"}, clr_n, v.exp_clr);
        checkOutput({tag, " pat_rd_en"}, rd_n, v.exp_rd);
        checkOutput({tag, " done"}, done_n, 1);
        checkOutput({tag, " addr_seq_errs"}, addr_err, 0);
        checkOutput({tag, " pat_we_errs"}, we_err, 0);
        checkOutput({tag, " ts_wrap_errs"}, ts_err, 0);
        if (v.sim_t > 0) checkOutput({tag, " last_addr"}, last_addr, 2 * v.sim_t - 1);
        @(posedge clk);
        #3;
        checkOutput({tag, " idle_busy"}, busy, 0);
        checkOutput({tag, " idle_done"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit         found;
        int         done_seen;
        logic [3:0] done_pat;
        applied     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        sim_time    = '0;
        man_done    = '0;
        auto_resp   = 0;
        resp_delay  = 3;

        vecs[0] = '{2,   3, 25,   2,   1, 4};
        vecs[1] = '{0,   3, 1,    0,   0, 0};
        vecs[2] = '{1,   1, 9,    1,   1, 2};
        vecs[3] = '{3,   2, 31,   3,   1, 6};
        vecs[4] = '{256, 1, 2049, 256, 1, 512};
        vecs[5] = '{5,   4, 71,   5,   1, 10};

        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst timestep", timestep, 0);
        checkOutput("rst pat_rd_en", pat_rd_en, 0);
        checkOutput("rst pat_rd_addr", pat_rd_addr, 0);
        checkOutput("rst pat_we", pat_we, 0);
        checkOutput("rst pat_sel", pat_sel, 0);
        checkOutput("rst neuron_clr", neuron_clr, 0);
        checkOutput("rst layer_start", layer_start, 0);
        checkOutput("rst spk_cnt_en", spk_cnt_en, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort while waiting on layer 1 in timestep 5.
        auto_resp  = 1;
        resp_delay = 3;
        found      = 0;
        done_seen  = 0;
        @(posedge clk);
        #1;
        sim_time = 9'd10;
        start    = 1'b1;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            #2;
            if (done) done_seen++;
            if (layer_start[1] && timestep == 8'd5) found = 1;
        end
        checkOutput("abort reach_ts5_l1", found, 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #3;
        abort = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort timestep", timestep, 0);
        checkOutput("abort layer_start", layer_start, 0);
        checkOutput("abort pat_we", pat_we, 0);
        repeat (3) begin
            @(posedge clk);
            #3;
            if (done) done_seen++;
        end
        checkOutput("abort no_done", done_seen, 0);
        applyStimulus(vecs[2], "after_abort");

        // Stray and early layer_done pulses with a manually driven layer interface.
        auto_resp = 0;
        man_done  = '0;
        found     = 0;
        @(posedge clk);
        #1;
        sim_time = 9'd1;
        start    = 1'b1;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (layer_start[0]) begin
                found    = 1;
                man_done = 2'b01;
            end
        end
        checkOutput("stray l0_started", found, 1);
        @(posedge clk); #1; man_done = 2'b10; #2;
        checkOutput("stray early_l0_ignored", layer_start, 0);
        @(posedge clk); #1; man_done = 2'b00; #2;
        checkOutput("stray l1_done_ignored", layer_start, 0);
        @(posedge clk); #1; man_done = 2'b01; #2;
        checkOutput("stray l0_done_no_spk", spk_cnt_en, 0);
        @(posedge clk); #1; man_done = 2'b00; #2;
        checkOutput("stray l1_start", layer_start, 2'b10);
        @(posedge clk); #1; man_done = 2'b10; #2;
        checkOutput("stray spk_same_cycle", spk_cnt_en, 1);
        @(posedge clk); #1; man_done = 2'b00;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk);
            #3;
            if (done) found = 1;
        end
        checkOutput("stray done", found, 1);

        // Level-high start with sim_time 0: DONE and IDLE alternate.
        done_pat = '0;
        @(posedge clk);
        #1;
        sim_time = 9'd0;
        start    = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #3;
            done_pat = {done_pat[2:0], done};
        end
        start = 1'b0;
        checkOutput("b2b done_pattern", done_pat, 4'b1010);
        @(posedge clk);
        #3;
        checkOutput("b2b stopped", done, 0);

        // Async reset between edges during FETCH.
        auto_resp  = 1;
        resp_delay = 3;
        found      = 0;
        @(posedge clk);
        #1;
        sim_time = 9'd3;
        start    = 1'b1;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (pat_rd_en) found = 1;
        end
        checkOutput("areset in_fetch", found, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset busy", busy, 0);
        checkOutput("areset pat_rd_en", pat_rd_en, 0);
        checkOutput("areset pat_rd_addr", pat_rd_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0], "after_areset");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
